// File: rtl/game_timer_pkg.sv
// game_timer_pkg
//   Shared definitions for the round countdown timer: FSM state encoding,
//   BCD digit width, mm:ss limits, bonus credit width and the saturating
//   credit-update helper used by the top level.
package game_timer_pkg;

  localparam int DIGIT_W = 4;   // one BCD digit
  localparam int BONUS_W = 8;   // bonus_pending credit counter width
  localparam int MAX_MIN = 99;
  localparam int MAX_SEC = 59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_e;

  // Credit left after one unit is consumed this cycle, with an optional new
  // bonus added in the same cycle: sat255(pend - 1 + amount). Only called
  // when at least one unit is available, so the subtraction cannot underflow.
  function automatic logic [BONUS_W-1:0] credit_after_unit(
    input logic [BONUS_W-1:0] pend,
    input logic               add_bonus,
    input logic [BONUS_W-1:0] amount
  );
    logic [BONUS_W+1:0] sum;
    sum = {2'b00, pend}
        + (add_bonus ? {2'b00, amount} : {(BONUS_W+2){1'b0}})
        - (BONUS_W+2)'(1);
    if (sum > {2'b00, {BONUS_W{1'b1}}}) begin
      return {BONUS_W{1'b1}};
    end
    return sum[BONUS_W-1:0];
  endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// bcd_mmss_counter
//   Four-digit BCD mm:ss register (00:00..99:59) with load, increment and
//   decrement. Increment holds at 99:59 and decrement holds at 00:00, so the
//   value never leaves the legal range. Priority: load > inc > dec.
//   Optional (GAME_TIMER_WARN_EN): low_next_o flags that the value being
//   written this cycle is 00:ss with ss <= LOW_SEC.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   load_i, inc_i, dec_i        controls
//   load_{mt,mo,st,so}_i        value loaded on load_i
//   {mt,mo,st,so}_o             registered digits
//   zero_o, max_o               value is 00:00 / 99:59
//   low_next_o                  (GAME_TIMER_WARN_EN only) see above
module bcd_mmss_counter
  import game_timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] RST_MT = '0,
  parameter logic [DIGIT_W-1:0] RST_MO = '0,
  parameter logic [DIGIT_W-1:0] RST_ST = '0,
  parameter logic [DIGIT_W-1:0] RST_SO = '0
`ifdef GAME_TIMER_WARN_EN
  ,
  parameter int LOW_SEC = 10
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               inc_i,
  input  logic               dec_i,
  input  logic [DIGIT_W-1:0] load_mt_i,
  input  logic [DIGIT_W-1:0] load_mo_i,
  input  logic [DIGIT_W-1:0] load_st_i,
  input  logic [DIGIT_W-1:0] load_so_i,
  output logic [DIGIT_W-1:0] mt_o,
  output logic [DIGIT_W-1:0] mo_o,
  output logic [DIGIT_W-1:0] st_o,
  output logic [DIGIT_W-1:0] so_o,
  output logic               zero_o,
  output logic               max_o
`ifdef GAME_TIMER_WARN_EN
  ,
  output logic               low_next_o
`endif
);

  localparam logic [DIGIT_W-1:0] DIG_ZERO = '0;
  localparam logic [DIGIT_W-1:0] DIG_ONE  = DIGIT_W'(1);
  localparam logic [DIGIT_W-1:0] DIG_NINE = DIGIT_W'(9);
  localparam logic [DIGIT_W-1:0] MAX_MT   = DIGIT_W'(MAX_MIN / 10);
  localparam logic [DIGIT_W-1:0] MAX_MO   = DIGIT_W'(MAX_MIN % 10);
  localparam logic [DIGIT_W-1:0] MAX_ST   = DIGIT_W'(MAX_SEC / 10);
  localparam logic [DIGIT_W-1:0] MAX_SO   = DIGIT_W'(MAX_SEC % 10);

  logic [DIGIT_W-1:0] mt_q, mo_q, st_q, so_q;
  logic [DIGIT_W-1:0] mt_d, mo_d, st_d, so_d;

  assign zero_o = (mt_q == DIG_ZERO) && (mo_q == DIG_ZERO) &&
                  (st_q == DIG_ZERO) && (so_q == DIG_ZERO);
  assign max_o  = (mt_q == MAX_MT) && (mo_q == MAX_MO) &&
                  (st_q == MAX_ST) && (so_q == MAX_SO);

  always_comb begin
    mt_d = mt_q;
    mo_d = mo_q;
    st_d = st_q;
    so_d = so_q;
    if (load_i) begin
      mt_d = load_mt_i;
      mo_d = load_mo_i;
      st_d = load_st_i;
      so_d = load_so_i;
    end else if (inc_i && !max_o) begin
      // Carry ripples so_ -> st_ -> mo_ -> mt_; mt_ cannot overflow because
      // 99:59 is excluded above.
      if (so_q != DIG_NINE) begin
        so_d = so_q + DIG_ONE;
      end else begin
        so_d = DIG_ZERO;
        if (st_q != MAX_ST) begin
          st_d = st_q + DIG_ONE;
        end else begin
          st_d = DIG_ZERO;
          if (mo_q != DIG_NINE) begin
            mo_d = mo_q + DIG_ONE;
          end else begin
            mo_d = DIG_ZERO;
            mt_d = mt_q + DIG_ONE;
          end
        end
      end
    end else if (dec_i && !zero_o) begin
      if (so_q != DIG_ZERO) begin
        so_d = so_q - DIG_ONE;
      end else begin
        so_d = DIG_NINE;
        if (st_q != DIG_ZERO) begin
          st_d = st_q - DIG_ONE;
        end else begin
          st_d = MAX_ST;
          if (mo_q != DIG_ZERO) begin
            mo_d = mo_q - DIG_ONE;
          end else begin
            mo_d = DIG_NINE;
            mt_d = mt_q - DIG_ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mt_q <= RST_MT;
      mo_q <= RST_MO;
      st_q <= RST_ST;
      so_q <= RST_SO;
    end else begin
      mt_q <= mt_d;
      mo_q <= mo_d;
      st_q <= st_d;
      so_q <= so_d;
    end
  end

  assign mt_o = mt_q;
  assign mo_o = mo_q;
  assign st_o = st_q;
  assign so_o = so_q;

`ifdef GAME_TIMER_WARN_EN
  logic [6:0] sec_next;
  assign sec_next   = 7'(st_d) * 7'd10 + 7'(so_d);
  assign low_next_o = (mt_d == DIG_ZERO) && (mo_d == DIG_ZERO) &&
                      (sec_next <= 7'(LOW_SEC));
`endif

endmodule

// File: rtl/game_countdown_timer.sv
// game_countdown_timer
//   Round timer: counts a preset mm:ss down to 00:00 in BCD on one_sec_tick,
//   with start / pause-toggle / abort, bonus-time credit applied one second
//   per clock, and a single-cycle time_up pulse on expiry.
//   Optional macro GAME_TIMER_WARN_EN adds the registered low-time 'warn'
//   output (threshold WARN_SEC).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, pause, abort   single-cycle control requests (abort > start > pause)
//   one_sec_tick          single-cycle seconds pulse
//   bonus                 single-cycle request to add BONUS_SEC seconds
//   min_tens..sec_ones    registered BCD digits
//   running               registered, high while RUNNING
//   warn                  (GAME_TIMER_WARN_EN only) registered low-time flag
//   time_up               registered single-cycle expiry pulse
module game_countdown_timer
  import game_timer_pkg::*;
#(
  parameter int START_MIN = 1,
  parameter int START_SEC = 30,
  parameter int BONUS_SEC = 5,
  parameter int WARN_SEC  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  input  logic               one_sec_tick,
  input  logic               bonus,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               running,
`ifdef GAME_TIMER_WARN_EN
  output logic               warn,
`endif
  output logic               time_up
);

  localparam logic [DIGIT_W-1:0] PRE_MT = DIGIT_W'(START_MIN / 10);
  localparam logic [DIGIT_W-1:0] PRE_MO = DIGIT_W'(START_MIN % 10);
  localparam logic [DIGIT_W-1:0] PRE_ST = DIGIT_W'(START_SEC / 10);
  localparam logic [DIGIT_W-1:0] PRE_SO = DIGIT_W'(START_SEC % 10);
  localparam bit PRESET_ZERO = (START_MIN == 0) && (START_SEC == 0);
  localparam logic [BONUS_W-1:0] BONUS_AMT = BONUS_W'(BONUS_SEC);

  localparam bit PARAMS_OK = (START_MIN >= 0) && (START_MIN <= MAX_MIN) &&
                             (START_SEC >= 0) && (START_SEC <= MAX_SEC) &&
                             (BONUS_SEC >= 1) && (BONUS_SEC <= 255) &&
                             (WARN_SEC >= 0) && (WARN_SEC <= MAX_SEC);

  // Marker scope for out-of-range parameter sets; it elaborates to nothing
  // and makes a bad configuration visible in the design hierarchy.
  if (!PARAMS_OK) begin : g_params_out_of_range
  end

  timer_state_e        state_q, state_d;
  logic [BONUS_W-1:0]  pend_q, pend_d;
  logic                running_q;
  logic                time_up_q;

  logic cnt_load, cnt_inc, cnt_dec;
  logic cnt_zero, cnt_max, cnt_one;
  logic expire;
  logic tick_live;
  logic credit;

  logic [DIGIT_W-1:0] mt, mo, st, so;

`ifdef GAME_TIMER_WARN_EN
  logic cnt_low_next;
  logic warn_q;
`endif

  bcd_mmss_counter #(
    .RST_MT (PRE_MT),
    .RST_MO (PRE_MO),
    .RST_ST (PRE_ST),
    .RST_SO (PRE_SO)
`ifdef GAME_TIMER_WARN_EN
    ,
    .LOW_SEC(WARN_SEC)
`endif
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .inc_i      (cnt_inc),
    .dec_i      (cnt_dec),
    .load_mt_i  (PRE_MT),
    .load_mo_i  (PRE_MO),
    .load_st_i  (PRE_ST),
    .load_so_i  (PRE_SO),
    .mt_o       (mt),
    .mo_o       (mo),
    .st_o       (st),
    .so_o       (so),
    .zero_o     (cnt_zero),
    .max_o      (cnt_max)
`ifdef GAME_TIMER_WARN_EN
    ,
    .low_next_o (cnt_low_next)
`endif
  );

  assign cnt_one = (mt == '0) && (mo == '0) && (st == '0) &&
                   (so == DIGIT_W'(1));

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    cnt_dec  = 1'b0;
    expire   = 1'b0;
    // Ticks only count in RUNNING; a bonus arriving this cycle is usable at
    // once, so the first credited second shows on the same edge.
    tick_live = one_sec_tick && (state_q == ST_RUNNING);
    credit    = (pend_q != '0) || bonus;

    if (abort) begin
      state_d  = ST_IDLE;
      cnt_load = 1'b1;
      pend_d   = '0;
    end else if (start && (state_q == ST_IDLE || state_q == ST_EXPIRED)) begin
      cnt_load = 1'b1;
      pend_d   = '0;
      if (PRESET_ZERO) begin
        state_d = ST_EXPIRED;
        expire  = 1'b1;
      end else begin
        state_d = ST_RUNNING;
      end
    end else if (state_q == ST_RUNNING || state_q == ST_PAUSED) begin
      if (credit) begin
        if (!tick_live && cnt_max) begin
          // Display is pinned at 99:59: any further credit is dropped.
          pend_d = '0;
        end else begin
          // A tick cancels one credit unit instead of moving the digits.
          cnt_inc = !tick_live;
          pend_d  = credit_after_unit(pend_q, bonus, BONUS_AMT);
        end
      end else if (tick_live) begin
        cnt_dec = 1'b1;
        if (cnt_one || cnt_zero) begin
          expire  = 1'b1;
          state_d = ST_EXPIRED;
        end
      end
      // Pause acts on the state seen this cycle; expiry takes precedence.
      if (pause && !expire) begin
        state_d = (state_q == ST_RUNNING) ? ST_PAUSED : ST_RUNNING;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      running_q <= 1'b0;
      time_up_q <= 1'b0;
`ifdef GAME_TIMER_WARN_EN
      warn_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      running_q <= (state_d == ST_RUNNING);
      time_up_q <= expire;
`ifdef GAME_TIMER_WARN_EN
      warn_q    <= (state_d == ST_RUNNING || state_d == ST_PAUSED) &&
                   (pend_d == '0) && cnt_low_next;
`endif
    end
  end

  assign min_tens = mt;
  assign min_ones = mo;
  assign sec_tens = st;
  assign sec_ones = so;
  assign running  = running_q;
  assign time_up  = time_up_q;
`ifdef GAME_TIMER_WARN_EN
  assign warn     = warn_q;
`endif

endmodule

// File: tb/tb_game_countdown_timer.sv
// Testbench for game_countdown_timer. Three instances share one stimulus
// stream: default preset 01:30, preset 99:57 and preset 00:00. A reference
// model working in whole seconds tracks each instance every cycle.
module tb_game_countdown_timer;

  localparam int BONUS  = 5;
  localparam int WARN   = 10;
  localparam int MAXS   = 99 * 60 + 59;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAU = 2, M_EXP = 3;

  logic clk = 1'b0;
  logic rst, start, pause, abort, tick, bonus;
  logic [2:0][15:0] dig;
  logic [2:0]       run_o, tu_o;
`ifdef GAME_TIMER_WARN_EN
  logic [2:0]       warn_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  game_countdown_timer u0 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .one_sec_tick(tick), .bonus(bonus),
    .min_tens(dig[0][15:12]), .min_ones(dig[0][11:8]),
    .sec_tens(dig[0][7:4]), .sec_ones(dig[0][3:0]),
    .running(run_o[0]),
`ifdef GAME_TIMER_WARN_EN
    .warn(warn_o[0]),
`endif
    .time_up(tu_o[0]));

  game_countdown_timer #(.START_MIN(99), .START_SEC(57)) u1 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .one_sec_tick(tick), .bonus(bonus),
    .min_tens(dig[1][15:12]), .min_ones(dig[1][11:8]),
    .sec_tens(dig[1][7:4]), .sec_ones(dig[1][3:0]),
    .running(run_o[1]),
`ifdef GAME_TIMER_WARN_EN
    .warn(warn_o[1]),
`endif
    .time_up(tu_o[1]));

  game_countdown_timer #(.START_MIN(0), .START_SEC(0)) u2 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .one_sec_tick(tick), .bonus(bonus),
    .min_tens(dig[2][15:12]), .min_ones(dig[2][11:8]),
    .sec_tens(dig[2][7:4]), .sec_ones(dig[2][3:0]),
    .running(run_o[2]),
`ifdef GAME_TIMER_WARN_EN
    .warn(warn_o[2]),
`endif
    .time_up(tu_o[2]));

  // ---------------- reference model ----------------
  typedef struct {
    int st;
    int secs;
    int pend;
    bit running;
    bit time_up;
    bit warn;
  } mdl_t;

  mdl_t mdl[3];
  int   preset[3] = '{90, MAXS - 2, 0};

  function automatic mdl_t mstep(mdl_t m, int pre, bit s, bit p, bit a, bit t, bit b);
    mdl_t n;
    int avail;
    bit live;
    n = m;
    n.time_up = 0;
    if (a) begin
      n.st = M_IDLE; n.secs = pre; n.pend = 0;
    end else if (s && (m.st == M_IDLE || m.st == M_EXP)) begin
      n.secs = pre; n.pend = 0;
      if (pre == 0) begin n.st = M_EXP; n.time_up = 1; end
      else n.st = M_RUN;
    end else if (m.st == M_RUN || m.st == M_PAU) begin
      avail = m.pend + (b ? BONUS : 0);
      live  = t && (m.st == M_RUN);
      if (avail > 0) begin
        if (live) n.pend = (avail - 1 > 255) ? 255 : avail - 1;
        else if (m.secs == MAXS) n.pend = 0;
        else begin
          n.secs = m.secs + 1;
          n.pend = (avail - 1 > 255) ? 255 : avail - 1;
        end
      end else if (live) begin
        n.secs = m.secs - 1;
        if (n.secs <= 0) begin n.secs = 0; n.st = M_EXP; n.time_up = 1; end
      end
      if (p && n.st != M_EXP) n.st = (m.st == M_RUN) ? M_PAU : M_RUN;
    end
    n.running = (n.st == M_RUN);
    n.warn = (n.st == M_RUN || n.st == M_PAU) && n.secs <= WARN && n.pend == 0;
    return n;
  endfunction

  function automatic logic [15:0] to_bcd(int secs);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d digits", i), dig[i], to_bcd(mdl[i].secs));
      chk($sformatf("u%0d running", i), 16'(run_o[i]), 16'(mdl[i].running));
      chk($sformatf("u%0d time_up", i), 16'(tu_o[i]), 16'(mdl[i].time_up));
`ifdef GAME_TIMER_WARN_EN
      chk($sformatf("u%0d warn", i), 16'(warn_o[i]), 16'(mdl[i].warn));
`endif
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mdl[i].st = M_IDLE; mdl[i].secs = preset[i]; mdl[i].pend = 0;
      mdl[i].running = 0; mdl[i].time_up = 0; mdl[i].warn = 0;
    end
  endtask

  task automatic step(input bit s, input bit p, input bit a, input bit t, input bit b);
    start = s; pause = p; abort = a; tick = t; bonus = b;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) mdl[i] = mstep(mdl[i], preset[i], s, p, a, t, b);
    check_all();
    start = 0; pause = 0; abort = 0; tick = 0; bonus = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    model_reset();
    check_all();
    chk("reset u0 digits", dig[0], 16'h0130);
    rst = 0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 1, 0);
  endtask

  // ---------------- directed vectors (instance u0, preset 01:30) ----------------
  typedef struct {
    bit s, p, a, t, b;
    logic [15:0] dig;
    bit run;
    bit tu;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 0, 16'h0130, 1, 0};  // start
    vecs[1]  = '{0, 0, 0, 1, 0, 16'h0129, 1, 0};
    vecs[2]  = '{0, 0, 0, 1, 0, 16'h0128, 1, 0};
    vecs[3]  = '{0, 0, 0, 0, 1, 16'h0129, 1, 0};  // bonus credited at once
    vecs[4]  = '{0, 0, 0, 0, 0, 16'h0130, 1, 0};
    vecs[5]  = '{0, 0, 0, 1, 0, 16'h0130, 1, 0};  // tick cancels a unit
    vecs[6]  = '{0, 1, 0, 0, 0, 16'h0131, 0, 0};  // pause, credit continues
    vecs[7]  = '{0, 0, 0, 1, 0, 16'h0132, 0, 0};  // tick ignored while paused
    vecs[8]  = '{0, 1, 0, 0, 0, 16'h0132, 1, 0};  // resume
    vecs[9]  = '{0, 0, 0, 0, 0, 16'h0132, 1, 0};
    vecs[10] = '{0, 0, 0, 1, 0, 16'h0131, 1, 0};
    vecs[11] = '{1, 0, 0, 0, 0, 16'h0131, 1, 0};  // start ignored in RUNNING
    vecs[12] = '{0, 0, 1, 1, 0, 16'h0130, 0, 0};  // abort beats tick
    vecs[13] = '{0, 0, 0, 1, 0, 16'h0130, 0, 0};  // IDLE ignores tick
    vecs[14] = '{0, 0, 0, 0, 1, 16'h0130, 0, 0};  // IDLE ignores bonus
    vecs[15] = '{1, 0, 0, 0, 1, 16'h0130, 1, 0};  // start discards bonus
    vecs[16] = '{0, 0, 0, 0, 0, 16'h0130, 1, 0};
    vecs[17] = '{0, 0, 0, 1, 0, 16'h0129, 1, 0};

    rst = 1; start = 0; pause = 0; abort = 0; tick = 0; bonus = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    chk("reset u0 digits", dig[0], 16'h0130);
    chk("reset u1 digits", dig[1], 16'h9957);
    chk("reset u2 digits", dig[2], 16'h0000);
    rst = 0;

    for (int v = 0; v < 18; v++) begin
      step(vecs[v].s, vecs[v].p, vecs[v].a, vecs[v].t, vecs[v].b);
      chk($sformatf("vec%0d digits", v), dig[0], vecs[v].dig);
      chk($sformatf("vec%0d running", v), 16'(run_o[0]), 16'(vecs[v].run));
      chk($sformatf("vec%0d time_up", v), 16'(tu_o[0]), 16'(vecs[v].tu));
      $display("vec %0d: digits=%h running=%b time_up=%b", v, dig[0], run_o[0], tu_o[0]);
    end

    // Full countdown 01:30 -> 00:00; zero preset expires straight from start.
    do_reset();
    step(1, 0, 0, 0, 0);
    chk("t1 zero preset time_up", 16'(tu_o[2]), 16'h1);
    chk("t1 zero preset running", 16'(run_o[2]), 16'h0);
    for (int k = 1; k <= 90; k++) begin
      step(0, 0, 0, 1, 0);
      if (k == 89) begin
        chk("t1 digits at 89", dig[0], 16'h0001);
        chk("t1 time_up at 89", 16'(tu_o[0]), 16'h0);
      end
    end
    chk("t1 digits at 90", dig[0], 16'h0000);
    chk("t1 time_up at 90", 16'(tu_o[0]), 16'h1);
    chk("t1 running expired", 16'(run_o[0]), 16'h0);
    step(0, 0, 0, 1, 1);
    chk("t1 time_up single cycle", 16'(tu_o[0]), 16'h0);
    chk("t1 expired hold", dig[0], 16'h0000);
    step(1, 0, 0, 0, 0);
    chk("t1 restart digits", dig[0], 16'h0130);
    chk("t1 restart running", 16'(run_o[0]), 16'h1);
    $display("seq countdown: done");

    // Pause / resume at 00:45.
    do_reset();
    step(1, 0, 0, 0, 0);
    ticks(45);
    step(0, 1, 0, 0, 0);
    chk("t2 paused running", 16'(run_o[0]), 16'h0);
    ticks(5);
    chk("t2 paused digits", dig[0], 16'h0045);
    step(0, 1, 0, 0, 0);
    chk("t2 resumed running", 16'(run_o[0]), 16'h1);
    step(0, 0, 0, 1, 0);
    chk("t2 after resume", dig[0], 16'h0044);
    $display("seq pause: digits=%h", dig[0]);

    // Bonus at 00:58 with a tick mid-credit.
    do_reset();
    step(1, 0, 0, 0, 0);
    ticks(32);
    chk("t3 start point", dig[0], 16'h0058);
    step(0, 0, 0, 0, 1);
    chk("t3 bonus 1", dig[0], 16'h0059);
    step(0, 0, 0, 0, 0);
    chk("t3 bonus 2", dig[0], 16'h0100);
    step(0, 0, 0, 1, 0);
    chk("t3 tick cancels", dig[0], 16'h0100);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t3 final", dig[0], 16'h0102);
    $display("seq bonus: digits=%h", dig[0]);

    // Saturation at 99:59 (instance u1).
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("t4 9958", dig[1], 16'h9958);
    step(0, 0, 0, 0, 0);
    chk("t4 9959", dig[1], 16'h9959);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t4 saturated", dig[1], 16'h9959);
    step(0, 0, 0, 1, 0);
    chk("t4 credit cleared", dig[1], 16'h9958);
    $display("seq saturate: digits=%h", dig[1]);

    // Abort with tick, then asynchronous reset mid-run.
    do_reset();
    step(1, 0, 0, 0, 0);
    ticks(70);
    chk("t5 at 0020", dig[0], 16'h0020);
    step(0, 0, 1, 1, 0);
    chk("t5 abort digits", dig[0], 16'h0130);
    chk("t5 abort time_up", 16'(tu_o[0]), 16'h0);
    chk("t5 abort running", 16'(run_o[0]), 16'h0);
    step(1, 0, 0, 0, 0);
    ticks(3);
    @(negedge clk);
    rst = 1;
    #1;
    model_reset();
    chk("t5 async digits", dig[0], 16'h0130);
    chk("t5 async running", 16'(run_o[0]), 16'h0);
    chk("t5 async u1 digits", dig[1], 16'h9957);
    check_all();
    #1;
    rst = 0;
    $display("seq abort/reset: digits=%h", dig[0]);

`ifdef GAME_TIMER_WARN_EN
    do_reset();
    step(1, 0, 0, 0, 0);
    ticks(78);
    chk("t6 warn at 0012", 16'(warn_o[0]), 16'h0);
    for (int s = 11; s >= 0; s--) begin
      step(0, 0, 0, 1, 0);
      chk($sformatf("t6 warn at %0d", s), 16'(warn_o[0]), 16'((s >= 1 && s <= WARN) ? 1 : 0));
    end
    $display("seq warn: done");
`endif

    // Randomized stimulus against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(99) < 4, $urandom_range(99) < 5, $urandom_range(99) < 2,
           $urandom_range(99) < 30, $urandom_range(99) < ((n < 1500) ? 8 : 40));
      if (n % 500 == 499) $display("random: %0d cycles, failures so far %0d", n + 1, failures);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_countdown_timer.md
Name: game_countdown_timer

Overview:
- Round timer stage directly downstream of the one-second tick generator.
- Consumes one_sec_tick and counts a preset mm:ss value down to 00:00 as BCD digits, which go to the HUD/score renderer.
- Supports start, pause/resume and abort, plus bonus-time pickups that are credited one second per clock.
- Emits a single-cycle time_up pulse to the game FSM.

Parameters:
- START_MIN, 1: preset minutes, 0..99.
- START_SEC, 30: preset seconds, 0..59.
- BONUS_SEC, 5: seconds credited per bonus pulse, 1..255.
- WARN_SEC, 10: low-time threshold in seconds, 0..59. Only used when GAME_TIMER_WARN_EN is defined.

Ports:
- clk  in  1  system clock; the same domain as one_sec_tick.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to (re)start from the preset.
- pause  in  1  single-cycle request to toggle between RUNNING and PAUSED.
- abort  in  1  single-cycle request to return to IDLE and reload the preset.
- one_sec_tick  in  1  single-cycle pulse from the upstream seconds timer.
- bonus  in  1  single-cycle request to add BONUS_SEC to the time.
- min_tens  out  4  BCD digit, 0..9.
- min_ones  out  4  BCD digit, 0..9.
- sec_tens  out  4  BCD digit, 0..5.
- sec_ones  out  4  BCD digit, 0..9.
- running  out  1  high while the state is RUNNING.
- time_up  out  1  single-cycle pulse when the count reaches 00:00.

Behaviour:
- Clock and reset:
  - One clock, clk. rst is asynchronous and active-high.
  - Reset values: state=IDLE, digits=preset, running=0, time_up=0, bonus_pending=0.
  - An rst assertion during any state returns immediately to these values.
- Registered outputs:
  - All outputs are registered.
  - Digit changes, running and time_up appear on the clock edge that samples the causing input (one-cycle latency).
- FSM states: IDLE, RUNNING, PAUSED, EXPIRED.
- Input priority in the same cycle: abort > start > pause.
- IDLE:
  - Digits hold the preset; one_sec_tick and bonus are ignored.
  - start -> RUNNING with digits reloaded.
- RUNNING:
  - one_sec_tick decrements the count by 1 second, with BCD borrow: sec_ones 0->9 borrows sec_tens; sec_tens 0->5 borrows min_ones; and so on.
  - pause -> PAUSED.
  - abort -> IDLE with the preset reloaded.
  - start is ignored.
- PAUSED:
  - one_sec_tick is ignored; bonus is still accepted.
  - pause -> RUNNING; abort -> IDLE.
- EXPIRED:
  - Digits hold 00:00; ticks and bonus are ignored.
  - start -> RUNNING with the preset reloaded; abort -> IDLE.
- Expiry:
  - A tick at 00:01 with bonus_pending=0 gives digits 00:00, state EXPIRED and time_up=1 for exactly one cycle.
  - Preset 00:00: start goes directly to EXPIRED with a time_up pulse.
- Bonus, RUNNING or PAUSED only:
  - bonus_pending is an 8-bit credit counter. A bonus pulse adds BONUS_SEC, saturating at 255.
  - Each cycle with bonus_pending>0: the count increments by 1 second (BCD carry) and bonus_pending decrements by 1.
  - At 99:59 the count saturates and bonus_pending is cleared to 0.
- Simultaneous events:
  - Tick with bonus_pending>0 in RUNNING: the tick cancels one pending unit. Digits are unchanged, bonus_pending decrements by 1, and there is no expiry.
  - bonus in the same cycle as a pending application: bonus_pending = bonus_pending - 1 + BONUS_SEC, saturating.
  - abort or start in the same cycle as a tick or bonus: the tick and bonus are discarded and bonus_pending is cleared.
- Invariant: digits always stay in the legal BCD/mm:ss range, 00:00..99:59.

Optional Feature:
- Macro: GAME_TIMER_WARN_EN.
- When defined:
  - Adds output port warn (1 bit, registered, reset 0).
  - warn is high in RUNNING or PAUSED when min_tens=min_ones=0, seconds ≤ WARN_SEC and bonus_pending=0.
  - warn is low in IDLE and EXPIRED.
- When undefined: no warn port, no comparator logic, and WARN_SEC is unused.

Decomposition:
- Shared include/package game_timer_pkg holds:
  - state encoding constants for IDLE, RUNNING, PAUSED, EXPIRED (2 bits);
  - BCD digit width (4);
  - MAX_MIN=99 and MAX_SEC=59;
  - the bonus_pending width (8).
- Sub-module bcd_mmss_counter:
  - four-digit mm:ss register;
  - load, inc and dec controls with carry/borrow chains;
  - zero flag and max (99:59) flag.
- The top level holds the FSM, bonus_pending and the pulse logic.

Test Plan:
1. Defaults 01:30; start, then 90 one_sec_tick pulses -> digits step 01:29 … 00:00; time_up high exactly one cycle after the 90th tick; state EXPIRED; running=0.
2. Running at 00:45; pause, 5 ticks, pause again, 1 tick -> digits 00:45 during pause, then 00:44; running low only while paused.
3. Running at 00:58; bonus (BONUS_SEC=5) -> digits 00:59, 01:00 … 01:03 on five consecutive clocks; a tick landing mid-credit cancels one unit, so the final value is 01:02.
4. Start with preset 99:57; bonus -> digits saturate at 99:59; bonus_pending=0 afterwards; no wrap to 00:00.
5. Running at 00:20; abort and tick in the same cycle -> IDLE, digits 01:30, no time_up. Then assert rst asynchronously mid-RUNNING -> outputs take their reset values before the next clk edge.
6. With GAME_TIMER_WARN_EN, WARN_SEC=10: count from 00:12 -> warn rises when the display shows 00:10, stays high through 00:01, and drops in EXPIRED.
